// File: rtl/oled_spi_byte_tx_if.sv
// ---------------------------------------------------------------
// oled_spi_byte_tx_if - byte/flag valid-ready handshake. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface oled_spi_byte_tx_if;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_dc, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_dc, input  tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/oled_spi_byte_tx.sv
// ---------------------------------------------------------------
// oled_spi_byte_tx - SPI mode-3 byte serializer for the PmodOLED.
// Optional input FIFO: OLED_SPI_TX_FIFO_EN. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module oled_spi_byte_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  oled_spi_byte_tx_if.slave tx,
  output logic              busy,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  output logic              SPI_CS,
  output logic              data_command
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("oled_spi_byte_tx: CLK_DIV must be 1..255");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("oled_spi_byte_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t     state, state_nx;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic       phase_hi;
  logic [6:0] shreg;

  logic       div_done, bit_end, load_pt, load;
  logic       ld_avail, ld_dc, fifo_nonempty;
  logic [7:0] ld_data;

  assign div_done = (div_cnt == 8'd0);
  assign bit_end  = (state == SHIFT) && phase_hi && div_done && (bit_cnt == 3'd0);
  // A new byte can only be taken from IDLE or exactly at the end of bit 0.
  assign load_pt  = !reset && ((state == IDLE) || bit_end);
  assign load     = load_pt && ld_avail;

`ifdef OLED_SPI_TX_FIFO_EN
  localparam int         AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;

  assign tx.tx_ready   = !reset && (count != FULL);
  assign push          = tx.tx_valid && tx.tx_ready;
  assign fifo_nonempty = (count != '0);
  assign pop           = load_pt && fifo_nonempty;
  assign ld_avail      = fifo_nonempty;
  assign ld_data       = mem[rd_ptr][7:0];
  assign ld_dc         = mem[rd_ptr][8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tx.tx_dc, tx.tx_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
`else
  assign tx.tx_ready   = load_pt;
  assign fifo_nonempty = 1'b0;
  assign ld_avail      = tx.tx_valid;
  assign ld_data       = tx.tx_data;
  assign ld_dc         = tx.tx_dc;
`endif

  assign busy = (state != IDLE) || fifo_nonempty;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = SETUP;
      SETUP:   if (div_done) state_nx = SHIFT;
      SHIFT:   if (bit_end && !ld_avail) state_nx = HOLD;
      HOLD:    if (div_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= 8'd0;
      bit_cnt      <= 3'd0;
      phase_hi     <= 1'b0;
      shreg        <= 7'd0;
      SPI_CLK      <= 1'b1;
      SPI_MOSI     <= 1'b0;
      SPI_CS       <= 1'b1;
      data_command <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg        <= ld_data[6:0];
            SPI_MOSI     <= ld_data[7];
            data_command <= ld_dc;
            SPI_CS       <= 1'b0;
            div_cnt      <= DIV_LAST;
          end
        end
        SETUP: begin
          if (div_done) begin
            SPI_CLK  <= 1'b0;
            phase_hi <= 1'b0;
            bit_cnt  <= 3'd7;
            div_cnt  <= DIV_LAST;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (!div_done) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LAST;
            if (!phase_hi) begin
              SPI_CLK  <= 1'b1;
              phase_hi <= 1'b1;
            end else if (bit_cnt != 3'd0) begin
              SPI_CLK  <= 1'b0;
              phase_hi <= 1'b0;
              bit_cnt  <= bit_cnt - 3'd1;
              SPI_MOSI <= shreg[6];
              shreg    <= {shreg[5:0], 1'b0};
            end else if (load) begin
              // Chained byte: reload on the falling edge that starts its bit 7.
              SPI_CLK      <= 1'b0;
              phase_hi     <= 1'b0;
              bit_cnt      <= 3'd7;
              shreg        <= ld_data[6:0];
              SPI_MOSI     <= ld_data[7];
              data_command <= ld_dc;
            end
          end
        end
        HOLD: begin
          if (div_done) SPI_CS  <= 1'b1;
          else          div_cnt <= div_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_byte_tx.sv
// Bench for oled_spi_byte_tx: a line-level SPI monitor decodes bytes and CS windows,
// compared against expectations built from the byte/timing rules.
`default_nettype none

module tb_oled_spi_byte_tx;

  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  oled_spi_byte_tx_if if4();
  oled_spi_byte_tx_if if1();

  logic busy4, sclk4, mosi4, cs4, dc4;
  logic busy1, sclk1, mosi1, cs1, dc1;

  oled_spi_byte_tx #(.CLK_DIV(DIV_A), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .tx(if4.slave), .busy(busy4),
    .SPI_CLK(sclk4), .SPI_MOSI(mosi4), .SPI_CS(cs4), .data_command(dc4));

  oled_spi_byte_tx #(.CLK_DIV(DIV_B), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .tx(if1.slave), .busy(busy1),
    .SPI_CLK(sclk1), .SPI_MOSI(mosi1), .SPI_CS(cs1), .data_command(dc1));

  int checks = 0;
  int errors = 0;

  // Monitor state, one slot per DUT.
  logic       p_sclk [2], p_mosi [2], p_cs [2], p_dc [2], byte_dc [2];
  logic [7:0] acc [2];
  logic [31:0] fall_dc [2];
  int cs_len [2], rises [2], nbits [2], falls [2], glitches [2];
  logic [9:0]  rx_q [$];
  int          win_id_q [$], win_len_q [$], win_rise_q [$];
  logic [31:0] win_fall_q [$];

  task automatic mon_step(input int id, input logic rst, input logic sclk, input logic mosi,
                          input logic cs, input logic dc, input logic bsy);
    if (rst) begin
      cs_len[id] = 0; rises[id] = 0; nbits[id] = 0; falls[id] = 0; fall_dc[id] = '0;
    end else if (cs === 1'b0) begin
      cs_len[id]++;
      if (bsy !== 1'b1) glitches[id]++;
      if (p_cs[id] === 1'b0) begin
        if (p_sclk[id] && sclk && (mosi !== p_mosi[id])) glitches[id]++;
        if ((dc !== p_dc[id]) && !(p_sclk[id] && !sclk)) glitches[id]++;
      end
      if (sclk && !p_sclk[id]) begin
        rises[id]++;
        acc[id] = {acc[id][6:0], mosi};
        if (nbits[id] == 0) byte_dc[id] = dc;
        else if (dc !== byte_dc[id]) glitches[id]++;
        nbits[id]++;
        if (nbits[id] == 8) begin
          rx_q.push_back({id == 1, byte_dc[id], acc[id]});
          nbits[id] = 0;
        end
      end
      if (!sclk && p_sclk[id]) begin
        if (falls[id] < 32) fall_dc[id][falls[id]] = dc;
        falls[id]++;
      end
    end else if (p_cs[id] === 1'b0) begin
      if (nbits[id] != 0) glitches[id]++;
      win_id_q.push_back(id); win_len_q.push_back(cs_len[id]);
      win_rise_q.push_back(rises[id]); win_fall_q.push_back(fall_dc[id]);
      cs_len[id] = 0; rises[id] = 0; nbits[id] = 0; falls[id] = 0; fall_dc[id] = '0;
    end
    p_sclk[id] = sclk; p_mosi[id] = mosi; p_cs[id] = cs; p_dc[id] = dc;
  endtask

  always @(negedge clk) begin
    mon_step(0, reset, sclk4, mosi4, cs4, dc4, busy4);
    mon_step(1, reset, sclk1, mosi1, cs1, dc1, busy1);
  end

  task automatic drive(input int id, input logic v, input logic [7:0] d, input logic dc);
    if (id == 0) begin if4.tx_valid = v; if4.tx_data = d; if4.tx_dc = dc; end
    else         begin if1.tx_valid = v; if1.tx_data = d; if1.tx_dc = dc; end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? if4.tx_ready : if1.tx_ready;
  endfunction

  // Offer one byte and return on the negedge after it was accepted (valid dropped).
  task automatic send(input int id, input logic [7:0] d, input logic dc);
    int k;
    drive(id, 1'b1, d, dc);
    k = 0;
    while (rdy(id) !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) begin
      checks++; errors++;
      $display("FAIL send_timeout id=%0d byte=%02h never accepted", id, d);
    end
    @(negedge clk);
    drive(id, 1'b0, d, dc);
  endtask

  task automatic wait_idle(input int id);
    int k;
    k = 0;
    @(negedge clk);
    while (((id == 0) ? busy4 : busy1) !== 1'b0 && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) begin
      checks++; errors++;
      $display("FAIL idle_timeout id=%0d busy never fell", id);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (cs4 !== 1'b1)   begin errors++; $display("FAIL rst_cs got %b exp 1", cs4); end
    checks++; if (sclk4 !== 1'b1) begin errors++; $display("FAIL rst_sclk got %b exp 1", sclk4); end
    checks++; if (mosi4 !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b exp 0", mosi4); end
    checks++; if (dc4 !== 1'b0)   begin errors++; $display("FAIL rst_dc got %b exp 0", dc4); end
    checks++; if (if4.tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", if4.tx_ready); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy4); end
    checks++; if (cs1 !== 1'b1)   begin errors++; $display("FAIL rst_cs1 got %b exp 1", cs1); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (if4.tx_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", if4.tx_ready); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b exp 0", busy4); end
  endtask

  task automatic test_single_byte;
    int r0, w0;
    r0 = rx_q.size(); w0 = win_len_q.size();
    send(0, 8'hA5, 1'b0);
    wait_idle(0);
    checks++; if (rx_q.size() != r0 + 1) begin errors++; $display("FAIL single_count got %0d exp %0d", rx_q.size() - r0, 1); end
    else begin
      checks++; if (rx_q[r0] !== {1'b0, 1'b0, 8'hA5}) begin errors++; $display("FAIL single_byte got %03h exp %03h", rx_q[r0], {1'b0, 1'b0, 8'hA5}); end
    end
    checks++; if (win_len_q.size() != w0 + 1) begin errors++; $display("FAIL single_windows got %0d exp 1", win_len_q.size() - w0); end
    else begin
      checks++; if (win_len_q[w0] != 18 * DIV_A) begin errors++; $display("FAIL single_cs_len got %0d exp %0d", win_len_q[w0], 18 * DIV_A); end
      checks++; if (win_rise_q[w0] != 8) begin errors++; $display("FAIL single_rises got %0d exp 8", win_rise_q[w0]); end
    end
  endtask

  task automatic test_back_to_back;
    int r0, w0;
    r0 = rx_q.size(); w0 = win_len_q.size();
    send(0, 8'hAF, 1'b0);
    send(0, 8'h3C, 1'b1);
    wait_idle(0);
    checks++; if (rx_q.size() != r0 + 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", rx_q.size() - r0); end
    else begin
      checks++; if (rx_q[r0] !== {1'b0, 1'b0, 8'hAF}) begin errors++; $display("FAIL b2b_byte0 got %03h exp %03h", rx_q[r0], {1'b0, 1'b0, 8'hAF}); end
      checks++; if (rx_q[r0+1] !== {1'b0, 1'b1, 8'h3C}) begin errors++; $display("FAIL b2b_byte1 got %03h exp %03h", rx_q[r0+1], {1'b0, 1'b1, 8'h3C}); end
    end
    checks++; if (win_len_q.size() != w0 + 1) begin errors++; $display("FAIL b2b_windows got %0d exp 1", win_len_q.size() - w0); end
    else begin
      checks++; if (win_len_q[w0] != 34 * DIV_A) begin errors++; $display("FAIL b2b_cs_len got %0d exp %0d", win_len_q[w0], 34 * DIV_A); end
      checks++; if (win_rise_q[w0] != 16) begin errors++; $display("FAIL b2b_rises got %0d exp 16", win_rise_q[w0]); end
      checks++; if (win_fall_q[w0][8:7] !== 2'b10) begin errors++; $display("FAIL b2b_dc_switch got %b exp 10", win_fall_q[w0][8:7]); end
    end
  endtask

`ifndef OLED_SPI_TX_FIFO_EN
  task automatic test_busy_holdoff;
    int k, first, r0, w0;
    logic [7:0] b1, b2;
    logic d1, d2;
    b1 = 8'($urandom); b2 = 8'($urandom); d1 = 1'($urandom); d2 = 1'($urandom);
    r0 = rx_q.size(); w0 = win_len_q.size();
    drive(0, 1'b1, b1, d1);
    k = 0; first = 0;
    while (k < 400 && first == 0) begin
      @(negedge clk); k++;
      if (k == 1)  drive(0, 1'b0, b1, d1);
      if (k == 20) drive(0, 1'b1, b2, d2);
      if (if4.tx_ready === 1'b1) first = k;
    end
    checks++; if (first != 17 * DIV_A) begin errors++; $display("FAIL holdoff_ready_at got %0d exp %0d", first, 17 * DIV_A); end
    @(negedge clk);
    drive(0, 1'b0, b2, d2);
    checks++; if (if4.tx_ready !== 1'b0) begin errors++; $display("FAIL holdoff_ready_pulse got %b exp 0", if4.tx_ready); end
    wait_idle(0);
    checks++; if (rx_q.size() != r0 + 2) begin errors++; $display("FAIL holdoff_count got %0d exp 2", rx_q.size() - r0); end
    else begin
      checks++; if (rx_q[r0] !== {1'b0, d1, b1}) begin errors++; $display("FAIL holdoff_b1 got %03h exp %03h", rx_q[r0], {1'b0, d1, b1}); end
      checks++; if (rx_q[r0+1] !== {1'b0, d2, b2}) begin errors++; $display("FAIL holdoff_b2 got %03h exp %03h", rx_q[r0+1], {1'b0, d2, b2}); end
    end
    checks++; if (win_len_q.size() != w0 + 1 || win_len_q[win_len_q.size()-1] != 34 * DIV_A) begin
      errors++; $display("FAIL holdoff_window got %0d windows exp 1 of len %0d", win_len_q.size() - w0, 34 * DIV_A);
    end
  endtask
`endif

  task automatic test_reset_mid;
    int k, r0, w0;
    r0 = rx_q.size();
    send(0, 8'hFF, 1'b1);
    k = 0;
    while (rises[0] < 4 && k < 500) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cs4 !== 1'b1 || sclk4 !== 1'b1 || mosi4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got cs=%b clk=%b mosi=%b busy=%b exp 1 1 0 0", cs4, sclk4, mosi4, busy4);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (rx_q.size() != r0) begin errors++; $display("FAIL midrst_partial got %0d bytes exp 0", rx_q.size() - r0); end
    w0 = win_len_q.size();
    send(0, 8'h00, 1'b0);
    wait_idle(0);
    checks++; if (rx_q.size() != r0 + 1 || rx_q[rx_q.size()-1] !== 10'h000) begin
      errors++; $display("FAIL midrst_next got %0d bytes exp 1 of 000", rx_q.size() - r0);
    end
    checks++; if (win_len_q.size() != w0 + 1 || win_len_q[win_len_q.size()-1] != 18 * DIV_A) begin
      errors++; $display("FAIL midrst_window got %0d windows exp 1 of len %0d", win_len_q.size() - w0, 18 * DIV_A);
    end
  endtask

  task automatic test_div1;
    int k, r0, bad;
    logic exp_clk;
    r0 = rx_q.size();
    send(1, 8'h81, 1'b1);
    k = 0;
    while (cs1 !== 1'b0 && k < 4) begin @(negedge clk); k++; end
    checks++; if (sclk1 !== 1'b1) begin errors++; $display("FAIL div1_setup_clk got %b exp 1", sclk1); end
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      exp_clk = (n % 2 == 1);
      if (sclk1 !== exp_clk) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL div1_toggle got %0d wrong cycles exp 0", bad); end
    wait_idle(1);
    checks++; if (rx_q.size() != r0 + 1 || rx_q[rx_q.size()-1] !== {1'b1, 1'b1, 8'h81}) begin
      errors++; $display("FAIL div1_byte got %0d bytes exp 1 of 381", rx_q.size() - r0);
    end
    checks++; if (win_len_q[win_len_q.size()-1] != 18 * DIV_B) begin
      errors++; $display("FAIL div1_cs_len got %0d exp %0d", win_len_q[win_len_q.size()-1], 18 * DIV_B);
    end
  endtask

  task automatic test_random;
    logic [9:0] exp_q [$];
    int exp_win [$];
    int r0, w0, nb;
    logic [7:0] d;
    logic dc;
    r0 = rx_q.size(); w0 = win_len_q.size();
    for (int c = 0; c < 6; c++) begin
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        d = 8'($urandom); dc = 1'($urandom);
        exp_q.push_back({1'b0, dc, d});
        send(0, d, dc);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      exp_win.push_back((2 + 16 * nb) * DIV_A);
      wait_idle(0);
    end
    checks++; if (rx_q.size() - r0 != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", rx_q.size() - r0, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && r0 + i < rx_q.size(); i++) begin
      checks++; if (rx_q[r0+i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %03h exp %03h", i, rx_q[r0+i], exp_q[i]); end
    end
    checks++; if (win_len_q.size() - w0 != exp_win.size()) begin errors++; $display("FAIL rand_windows got %0d exp %0d", win_len_q.size() - w0, exp_win.size()); end
    for (int i = 0; i < exp_win.size() && w0 + i < win_len_q.size(); i++) begin
      checks++; if (win_len_q[w0+i] != exp_win[i]) begin errors++; $display("FAIL rand_cs_len%0d got %0d exp %0d", i, win_len_q[w0+i], exp_win[i]); end
    end
  endtask

`ifdef OLED_SPI_TX_FIFO_EN
  task automatic test_fifo;
    logic [9:0] exp_q [$];
    logic [7:0] d;
    logic dc, er;
    int r0, w0;
    r0 = rx_q.size(); w0 = win_len_q.size();
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom); dc = 1'($urandom);
      drive(0, 1'b1, d, dc);
      er = (i < 5);
      checks++; if (if4.tx_ready !== er) begin errors++; $display("FAIL fifo_ready%0d got %b exp %b", i, if4.tx_ready, er); end
      if (i < 5) exp_q.push_back({1'b0, dc, d});
      if (i < 5) @(negedge clk);
    end
    drive(0, 1'b0, 8'h00, 1'b0);
    wait_idle(0);
    checks++; if (rx_q.size() - r0 != 5) begin errors++; $display("FAIL fifo_count got %0d exp 5", rx_q.size() - r0); end
    for (int i = 0; i < 5 && r0 + i < rx_q.size(); i++) begin
      checks++; if (rx_q[r0+i] !== exp_q[i]) begin errors++; $display("FAIL fifo_byte%0d got %03h exp %03h", i, rx_q[r0+i], exp_q[i]); end
    end
    checks++; if (win_len_q.size() != w0 + 1 || win_len_q[win_len_q.size()-1] != 82 * DIV_A) begin
      errors++; $display("FAIL fifo_window got %0d windows exp 1 of len %0d", win_len_q.size() - w0, 82 * DIV_A);
    end
  endtask
`endif

  task automatic test_line_rules;
    checks++; if (glitches[0] != 0) begin errors++; $display("FAIL line_rules_div4 got %0d violations exp 0", glitches[0]); end
    checks++; if (glitches[1] != 0) begin errors++; $display("FAIL line_rules_div1 got %0d violations exp 0", glitches[1]); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
`ifndef OLED_SPI_TX_FIFO_EN
    test_busy_holdoff();
`endif
    test_reset_mid();
    test_div1();
    test_random();
`ifdef OLED_SPI_TX_FIFO_EN
    test_fifo();
`endif
    test_line_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
